// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding,
// default geometry and the pattern-length normalisation helper.
package pattern_gen_pkg;

  // Controller states; outputs are registered alongside the state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Default maximum pattern length in bits.
  localparam int MAX_LEN_DEF = 8;

  // Pattern held after reset (110101 in the low 6 bits).
  localparam logic [7:0] DEFAULT_PATTERN_DEF = 8'b0011_0101;

  // Length held after reset, matching the 6 meaningful bits above.
  localparam logic [3:0] DEFAULT_LEN = 4'd6;

  // A length of 0 or anything above the maximum means "use the maximum".
  function automatic logic [3:0] eff_len(input logic [3:0] len, input int max_len);
    if ((len == 4'd0) || (int'(len) > max_len)) begin
      return 4'(max_len);
    end
    return len;
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable MSB-first shifter. Keeps a latched copy of the pattern and its
// length so a repetition can restart at the MSB without the external inputs.
// The working register is left-aligned so the next bit is always at the top.
module pattern_shift_reg
  import pattern_gen_pkg::*;
#(
  parameter int                 MAX_LEN         = MAX_LEN_DEF,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = DEFAULT_PATTERN_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,        // latch new pattern/length and align it
  input  logic               restart,     // emit MSB of latched pattern, queue the rest
  input  logic               shift,       // emit the top bit of the working register
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [3:0]         len_in,      // already normalised to 1..MAX_LEN
  output logic               bit_out,     // bit being emitted this cycle
  output logic [3:0]         len_out      // latched length
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [3:0]         len_q, len_d;
  logic [MAX_LEN-1:0] aligned_in;
  logic [MAX_LEN-1:0] aligned_lat;

  // Move bit len-1 up to the top of the register.
  function automatic logic [MAX_LEN-1:0] align(input logic [MAX_LEN-1:0] p,
                                               input logic [3:0]         l);
    logic [3:0] sa;
    sa = 4'(MAX_LEN) - l;
    return p << sa;
  endfunction

  assign aligned_in  = align(pattern_in, len_in);
  assign aligned_lat = align(pat_q, len_q);

  // On restart the first bit comes straight from the latched copy so that
  // back-to-back repetitions need no bubble cycle.
  assign bit_out = restart ? aligned_lat[MAX_LEN-1] : shift_q[MAX_LEN-1];
  assign len_out = len_q;

  // Next-value selection: load wins, then restart, then plain shift.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    shift_d = shift_q;
    if (load) begin
      pat_d   = pattern_in;
      len_d   = len_in;
      shift_d = aligned_in;
    end else if (restart) begin
      shift_d = aligned_lat << 1;
    end else if (shift) begin
      shift_d = shift_q << 1;
    end
  end

  // Storage with asynchronous return to the default pattern.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= DEFAULT_LEN;
      shift_q <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern generator: on start, sends a latched pattern MSB-first,
// rep+1 times with gap idle cycles between repetitions, then pulses done.
// Outputs are registered and change on the same edge as the state.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int                 MAX_LEN         = MAX_LEN_DEF,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = DEFAULT_PATTERN_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         pat_len,
  input  logic [3:0]         rep,
  input  logic [3:0]         gap,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;   // bits still to emit after the current one
  logic [3:0] gap_cnt_q, gap_cnt_d;   // idle cycles still to spend after this one
  logic [4:0] rep_cnt_q, rep_cnt_d;   // repetitions remaining after the current one
  logic [3:0] gap_len_q, gap_len_d;   // latched gap length
  logic       out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       sr_load;
  logic       sr_restart;
  logic       sr_shift;
  logic       sr_bit;
  logic [3:0] sr_len;

  pattern_shift_reg #(
    .MAX_LEN         (MAX_LEN),
    .DEFAULT_PATTERN (DEFAULT_PATTERN)
  ) u_shift (
    .clk        (clk),
    .rstn       (rstn),
    .load       (sr_load),
    .restart    (sr_restart),
    .shift      (sr_shift),
    .pattern_in (pattern),
    .len_in     (eff_len(pat_len, MAX_LEN)),
    .bit_out    (sr_bit),
    .len_out    (sr_len)
  );

  // Next state, counters and registered outputs; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_len_d   = gap_len_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_restart  = 1'b0;
    sr_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_load   = 1'b1;
          rep_cnt_d = {1'b0, rep};
          gap_len_d = gap;
          state_d   = ST_LOAD;
          busy_d    = 1'b1;
        end
      end

      ST_LOAD: begin
        // First bit leaves on the edge that ends LOAD.
        sr_shift    = 1'b1;
        out_d       = sr_bit;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        bit_cnt_d   = sr_len - 4'd1;
        state_d     = ST_SHIFT;
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        if (bit_cnt_q != 4'd0) begin
          sr_shift    = 1'b1;
          out_d       = sr_bit;
          out_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q - 4'd1;
        end else if (rep_cnt_q != 5'd0) begin
          rep_cnt_d = rep_cnt_q - 5'd1;
          if (gap_len_q != 4'd0) begin
            gap_cnt_d = gap_len_q - 4'd1;
            state_d   = ST_GAP;
          end else begin
            // Zero gap: next repetition's MSB follows immediately.
            sr_restart  = 1'b1;
            out_d       = sr_bit;
            out_valid_d = 1'b1;
            bit_cnt_d   = sr_len - 4'd1;
          end
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == 4'd0) begin
          sr_restart  = 1'b1;
          out_d       = sr_bit;
          out_valid_d = 1'b1;
          bit_cnt_d   = sr_len - 4'd1;
          state_d     = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 4'd0;
      gap_cnt_d   = 4'd0;
      rep_cnt_d   = 5'd0;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      sr_load     = 1'b0;
      sr_restart  = 1'b0;
      sr_shift    = 1'b0;
    end
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      gap_cnt_q   <= 4'd0;
      rep_cnt_q   <= 5'd0;
      gap_len_q   <= 4'd0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_len_q   <= gap_len_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen. Each run records out_valid/out/done/busy
// per cycle into bit masks (bit k = k-th cycle after start was sampled,
// k=0 being the LOAD cycle) and compares them with hand-derived masks.
module tb_pattern_gen;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [3:0] rep;
  logic [3:0] gap;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  logic [63:0] v_s, o_s, d_s, b_s;

  pattern_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .pat_len   (pat_len),
    .rep       (rep),
    .gap       (gap),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present start with the given parameters for one edge, then scramble the
  // inputs so any late sampling would corrupt the stream.
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g, input logic with_abort);
    @(negedge clk);
    pattern = p; pat_len = l; rep = r; gap = g;
    start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    pattern = ~p; pat_len = 4'd5; rep = 4'd7; gap = 4'd3;
  endtask

  // Record n cycles; optionally pulse start/abort during cycle inj_k.
  task automatic capture(input int n, input int inj_k, input logic inj_start,
                         input logic inj_abort);
    v_s = '0; o_s = '0; d_s = '0; b_s = '0;
    for (int k = 0; k < n; k++) begin
      v_s[k] = out_valid;
      o_s[k] = out;
      d_s[k] = done;
      b_s[k] = busy;
      if (k == inj_k) begin
        start = inj_start;
        abort = inj_abort;
        if (inj_start) begin
          pattern = 8'hFF; pat_len = 4'd2; rep = 4'd3; gap = 4'd1;
        end
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic expect_run(input string tag, input logic [63:0] ev, input logic [63:0] eo,
                            input logic [63:0] ed, input logic [63:0] eb);
    check({tag, ".valid"}, v_s, ev);
    check({tag, ".out"},   o_s, eo);
    check({tag, ".done"},  d_s, ed);
    check({tag, ".busy"},  b_s, eb);
    $display("tx %-12s valid=0x%0h out=0x%0h done=0x%0h busy=0x%0h", tag, v_s, o_s, d_s, b_s);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; pat_len = 4'd0; rep = 4'd0; gap = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.outs", {60'd0, out, out_valid, busy, done}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle.outs", {60'd0, out, out_valid, busy, done}, 64'd0);

    // 0x35, len 6, single shot: 110101 at k=1..6, done at k=7
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    capture(10, -1, 1'b0, 1'b0);
    expect_run("basic", 64'h7E, 64'h56, 64'h80, 64'h7F);

    // 0x05, len 3, rep 2, gap 2: 101 _ _ 101 _ _ 101, done at k=14
    send(8'h05, 4'd3, 4'd2, 4'd2, 1'b0);
    capture(16, -1, 1'b0, 1'b0);
    expect_run("gap2", 64'h39CE, 64'h294A, 64'h4000, 64'h3FFF);

    // 0x9, len 4, rep 1, gap 0, start together with abort in IDLE
    send(8'h09, 4'd4, 4'd1, 4'd0, 1'b1);
    capture(11, -1, 1'b0, 1'b0);
    expect_run("nogap", 64'h1FE, 64'h132, 64'h200, 64'h1FF);

    // Length 0 and length 12 both mean 8 bits
    send(8'hA5, 4'd0, 4'd0, 4'd0, 1'b0);
    capture(11, -1, 1'b0, 1'b0);
    expect_run("len0", 64'h1FE, 64'h14A, 64'h200, 64'h1FF);
    send(8'hA5, 4'd12, 4'd0, 4'd0, 1'b0);
    capture(11, -1, 1'b0, 1'b0);
    expect_run("len12", 64'h1FE, 64'h14A, 64'h200, 64'h1FF);

    // rep 15 with len 1: 16 contiguous ones, done at k=17
    send(8'h01, 4'd1, 4'd15, 4'd0, 1'b0);
    capture(19, -1, 1'b0, 1'b0);
    expect_run("rep15", 64'h1FFFE, 64'h1FFFE, 64'h20000, 64'h1FFFF);

    // Abort on the 3rd valid bit (k=3)
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    capture(8, 3, 1'b0, 1'b1);
    expect_run("abort", 64'hE, 64'h6, 64'h0, 64'hF);

    // start while busy (new params) and start during DONE are both ignored
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    capture(10, 2, 1'b1, 1'b0);
    expect_run("busy_start", 64'h7E, 64'h56, 64'h80, 64'h7F);
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    capture(10, 7, 1'b1, 1'b0);
    expect_run("done_start", 64'h7E, 64'h56, 64'h80, 64'h7F);

    // Reset mid-SHIFT clears outputs without a clock edge
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst.valid", {63'd0, out_valid}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst.outs", {60'd0, out, out_valid, busy, done}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    send(8'h35, 4'd6, 4'd0, 4'd0, 1'b0);
    capture(10, -1, 1'b0, 1'b0);
    expect_run("after_rst", 64'h7E, 64'h56, 64'h80, 64'h7F);

    // start honoured on the very first edge after reset release
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    pattern = 8'h05; pat_len = 4'd3; rep = 4'd0; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    capture(6, -1, 1'b0, 1'b0);
    expect_run("first_edge", 64'hE, 64'hA, 64'h10, 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
